// File: rtl/wr_engine_mo.sv
// AXI4 write-benchmark engine: issues strided write bursts with up to MAX_OUTSTANDING
// bursts in flight, counts B errors, and times the run (total or per-burst latency).
module wr_engine_mo #(
   parameter int ADDR_WIDTH      = 33,
   parameter int DATA_WIDTH      = 512,
   parameter int PARAMS_BITS     = 256,
   parameter int ID_WIDTH        = 5,
   parameter int NUM_IDS         = 4,
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [PARAMS_BITS-1:0]    lt_params,
   output logic                      end_of_exec,
   output logic [63:0]               lat_timer_sum,
   output logic [31:0]               bresp_err_cnt,
   output logic                      m_axi_AWVALID,
   input  logic                      m_axi_AWREADY,
   output logic [ADDR_WIDTH-1:0]     m_axi_AWADDR,
   output logic [ID_WIDTH-1:0]       m_axi_AWID,
   output logic [7:0]                m_axi_AWLEN,
   output logic [2:0]                m_axi_AWSIZE,
   output logic [1:0]                m_axi_AWBURST,
   output logic                      m_axi_WVALID,
   input  logic                      m_axi_WREADY,
   output logic [DATA_WIDTH-1:0]     m_axi_WDATA,
   output logic [DATA_WIDTH/8-1:0]   m_axi_WSTRB,
   output logic                      m_axi_WLAST,
   input  logic                      m_axi_BVALID,
   input  logic [1:0]                m_axi_BRESP,
   input  logic [ID_WIDTH-1:0]       m_axi_BID,
   output logic                      m_axi_BREADY
);
   localparam int SZ  = $clog2(DATA_WIDTH / 8);
   localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
   localparam int REP = DATA_WIDTH / 64;

   typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_t;
   state_t state, state_nxt;

   logic                   start_q;
   logic [PARAMS_BITS-1:0] params_q;
   logic [31:0]            wgs_m1, stride, offset, offset_nxt, beats;
   logic [63:0]            num_ops, aw_cnt, aw_cnt_nxt, w_burst_cnt;
   logic [ADDR_WIDTH-1:0]  init_addr;
   logic                   lat_mode, pat_en;
   logic [7:0]             awlen, awlen_p, beat;
   logic [OW-1:0]          outstanding, out_nxt;
   logic                   aw_hs, w_hs, b_hs, aw_more, active;
   logic                   unused_bits;

   assign unused_bits = ^{params_q[PARAMS_BITS-1:242], params_q[239:ADDR_WIDTH+160], m_axi_BID};

   assign beats = params_q[159:128] >> SZ;
   always_comb begin
      awlen_p = 8'd0;
      if (beats > 32'd256)     awlen_p = 8'd255;
      else if (beats != 32'd0) awlen_p = 8'(beats - 32'd1);
   end

   assign m_axi_AWLEN   = awlen;
   assign m_axi_AWSIZE  = 3'(SZ);
   assign m_axi_AWBURST = 2'b01;
   assign m_axi_WSTRB   = '1;
   assign m_axi_BREADY  = 1'b1;

   // W only for bursts whose AW was already accepted on an earlier edge
   assign m_axi_WVALID = (state == RUN) && (w_burst_cnt < aw_cnt);
   assign m_axi_WLAST  = (beat == awlen);
   assign m_axi_WDATA  = pat_en ? {REP{w_burst_cnt[31:0], 24'd0, beat}} : '0;

   assign aw_hs  = m_axi_AWVALID & m_axi_AWREADY;
   assign w_hs   = m_axi_WVALID & m_axi_WREADY;
   assign b_hs   = m_axi_BVALID & (outstanding != '0);
   assign active = (state == RUN) || (state == DRAIN);

   assign aw_cnt_nxt = aw_cnt + (aw_hs ? 64'd1 : 64'd0);
   assign offset_nxt = offset + (aw_hs ? stride : 32'd0);

   always_comb begin
      out_nxt = outstanding;
      if (aw_hs && !b_hs)      out_nxt = outstanding + OW'(1);
      else if (!aw_hs && b_hs) out_nxt = outstanding - OW'(1);
   end

   assign aw_more = (aw_cnt_nxt < num_ops) && (out_nxt < OW'(MAX_OUTSTANDING)) &&
                    (!lat_mode || out_nxt == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_q) state_nxt = INIT;
         INIT:    state_nxt = (num_ops == 64'd0) ? DONE : RUN;
         RUN:     if (aw_cnt == num_ops && w_burst_cnt == aw_cnt) state_nxt = DRAIN;
         DRAIN:   if (outstanding == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         start_q       <= 1'b0;
         params_q      <= '0;
         end_of_exec   <= 1'b0;
         lat_timer_sum <= 64'd0;
         bresp_err_cnt <= 32'd0;
         m_axi_AWVALID <= 1'b0;
         m_axi_AWADDR  <= '0;
         m_axi_AWID    <= '0;
         wgs_m1        <= 32'd0;
         stride        <= 32'd0;
         num_ops       <= 64'd0;
         init_addr     <= '0;
         lat_mode      <= 1'b0;
         pat_en        <= 1'b0;
         awlen         <= 8'd0;
         aw_cnt        <= 64'd0;
         w_burst_cnt   <= 64'd0;
         beat          <= 8'd0;
         offset        <= 32'd0;
         outstanding   <= '0;
      end else begin
         start_q     <= start;
         params_q    <= lt_params;
         end_of_exec <= (state == DONE);
         case (state)
            IDLE: if (start_q) begin
               wgs_m1    <= params_q[31:0] - 32'd1;
               stride    <= params_q[63:32];
               num_ops   <= params_q[127:64];
               awlen     <= awlen_p;
               init_addr <= params_q[ADDR_WIDTH+159:160];
               lat_mode  <= params_q[240];
               pat_en    <= params_q[241];
            end
            INIT: begin
               aw_cnt        <= 64'd0;
               w_burst_cnt   <= 64'd0;
               beat          <= 8'd0;
               offset        <= 32'd0;
               outstanding   <= '0;
               lat_timer_sum <= 64'd0;
               bresp_err_cnt <= 32'd0;
               // first request is ready on RUN entry: nothing is in flight yet
               m_axi_AWVALID <= (num_ops != 64'd0);
               m_axi_AWADDR  <= init_addr;
               m_axi_AWID    <= '0;
            end
            default: if (active) begin
               aw_cnt      <= aw_cnt_nxt;
               offset      <= offset_nxt;
               outstanding <= out_nxt;
               // AW fields only move once the current request is taken
               if (!m_axi_AWVALID || aw_hs) begin
                  m_axi_AWVALID <= aw_more;
                  m_axi_AWADDR  <= init_addr + ADDR_WIDTH'(offset_nxt & wgs_m1);
                  m_axi_AWID    <= ID_WIDTH'(aw_cnt_nxt & 64'(NUM_IDS - 1));
               end
               if (w_hs) begin
                  if (m_axi_WLAST) begin
                     beat        <= 8'd0;
                     w_burst_cnt <= w_burst_cnt + 64'd1;
                  end else begin
                     beat <= beat + 8'd1;
                  end
               end
               if (!lat_mode || outstanding != '0)
                  lat_timer_sum <= lat_timer_sum + 64'd1;
               if (b_hs && m_axi_BRESP != 2'b00 && bresp_err_cnt != 32'hFFFF_FFFF)
                  bresp_err_cnt <= bresp_err_cnt + 32'd1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_wr_engine_mo.sv
// Bench for wr_engine_mo: table of runs against a scoreboarded AXI slave model,
// plus hand sequences for outstanding cap, zero ops and mid-run reset.
module tb_wr_engine_mo;
   localparam int AW = 33, DW = 512, PB = 256, IW = 5;

   logic           clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [PB-1:0]  lt_params = '0;
   logic           eoe;
   logic [63:0]    lat_sum;
   logic [31:0]    err_cnt;
   logic           awvalid, awready = 1'b0;
   logic [AW-1:0]  awaddr;
   logic [IW-1:0]  awid;
   logic [7:0]     awlen;
   logic [2:0]     awsize;
   logic [1:0]     awburst;
   logic           wvalid, wready = 1'b0, wlast;
   logic [DW-1:0]  wdata;
   logic [DW/8-1:0] wstrb;
   logic           bvalid = 1'b0, bready;
   logic [1:0]     bresp = 2'b00;
   logic [IW-1:0]  bid = '0;

   wr_engine_mo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PARAMS_BITS(PB), .ID_WIDTH(IW),
                  .NUM_IDS(4), .MAX_OUTSTANDING(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .lt_params(lt_params),
      .end_of_exec(eoe), .lat_timer_sum(lat_sum), .bresp_err_cnt(err_cnt),
      .m_axi_AWVALID(awvalid), .m_axi_AWREADY(awready), .m_axi_AWADDR(awaddr),
      .m_axi_AWID(awid), .m_axi_AWLEN(awlen), .m_axi_AWSIZE(awsize), .m_axi_AWBURST(awburst),
      .m_axi_WVALID(wvalid), .m_axi_WREADY(wready), .m_axi_WDATA(wdata), .m_axi_WSTRB(wstrb),
      .m_axi_WLAST(wlast), .m_axi_BVALID(bvalid), .m_axi_BRESP(bresp), .m_axi_BID(bid),
      .m_axi_BREADY(bready));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] wgs, stride;
      logic [63:0] nops;
      logic [31:0] bbytes;
      logic [AW-1:0] init;
      bit lat, pat, rnd;
      int bdelay;
      logic [7:0] emask, exp_len;
      logic [31:0] exp_err;
   } vec_t;
   typedef struct { logic [AW-1:0] addr; logic [IW-1:0] id; logic [7:0] len; } exp_aw_t;
   typedef struct { logic [DW-1:0] data; bit last; } exp_w_t;
   typedef struct { int due; logic [1:0] resp; logic [IW-1:0] id; } bq_t;

   int checks = 0, errors = 0, ncyc = 0;
   exp_aw_t eaw[$];
   exp_w_t  ew[$];
   bq_t     bq[$];
   logic [IW-1:0] aid_q[$];
   int      aedge_q[$];

   bit rnd = 0, hold_b = 0; int bdelay = 1; logic [7:0] emask = '0;
   int aw_hs_cnt, wlast_cnt, b_cnt, bidx, outst, max_out, first_b_edge, aw5_edge, eoe_cnt, eoe_edge;
   bit any_valid, aw_stall, w_stall, s_last;
   logic [63:0] lat_model;
   logic [AW-1:0] s_addr; logic [IW-1:0] s_id; logic [DW-1:0] s_data;
   vec_t tbl[7];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, req);
      end
   endtask

   task sb_reset();
      eaw.delete(); ew.delete(); bq.delete(); aid_q.delete(); aedge_q.delete();
      aw_hs_cnt = 0; wlast_cnt = 0; b_cnt = 0; bidx = 0; outst = 0; max_out = 0;
      first_b_edge = -1; aw5_edge = -1; eoe_cnt = 0; eoe_edge = -1;
      any_valid = 0; aw_stall = 0; w_stall = 0; lat_model = 0;
   endtask

   // One negedge: drive slave inputs for the next posedge, score handshakes at that posedge.
   task step();
      exp_aw_t ea; exp_w_t e; bq_t b;
      @(negedge clk);
      ncyc++;
      awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!hold_b && bq.size() != 0 && bq[0].due <= ncyc + 1) begin
         bvalid = 1'b1; bid = bq[0].id; bresp = bq[0].resp;
      end else begin
         bvalid = 1'b0; bid = '0; bresp = 2'b00;
      end
      if (aw_stall) begin
         chk("aw_hold_valid", DW'(awvalid), 1);
         chk("aw_hold_addr", DW'(awaddr), DW'(s_addr));
         chk("aw_hold_id", DW'(awid), DW'(s_id));
      end
      if (w_stall) begin
         chk("w_hold_valid", DW'(wvalid), 1);
         chk("w_hold_data", wdata, s_data);
         chk("w_hold_last", DW'(wlast), DW'(s_last));
      end
      aw_stall = awvalid && !awready; s_addr = awaddr; s_id = awid;
      w_stall  = wvalid && !wready;   s_data = wdata;  s_last = wlast;
      if (wvalid && wready) begin
         chk("w_after_aw", DW'(aid_q.size() != 0), 1);
         chk("wstrb", DW'(wstrb), DW'({(DW/8){1'b1}}));
         if (ew.size() == 0) chk("w_extra", 1, 0);
         else begin
            e = ew.pop_front();
            chk("wdata", wdata, e.data);
            chk("wlast", DW'(wlast), DW'(e.last));
         end
         if (wlast) begin
            wlast_cnt++;
            b.due = ncyc + 1 + bdelay;
            b.resp = emask[bidx[2:0]] ? 2'b10 : 2'b00;
            b.id = (aid_q.size() != 0) ? aid_q.pop_front() : '0;
            bq.push_back(b);
            bidx++;
         end
      end
      if (awvalid && awready) begin
         aw_hs_cnt++; outst++;
         if (outst > max_out) max_out = outst;
         if (aw_hs_cnt == 5) aw5_edge = ncyc + 1;
         if (eaw.size() == 0) chk("aw_extra", 1, 0);
         else begin
            ea = eaw.pop_front();
            chk("awaddr", DW'(awaddr), DW'(ea.addr));
            chk("awid", DW'(awid), DW'(ea.id));
            chk("awlen", DW'(awlen), DW'(ea.len));
            chk("awsize", DW'(awsize), 6);
            chk("awburst", DW'(awburst), 1);
         end
         aid_q.push_back(awid);
         aedge_q.push_back(ncyc + 1);
      end
      if (bvalid) begin
         chk("bready", DW'(bready), 1);
         if (bq.size() != 0) void'(bq.pop_front());
         if (outst > 0) outst--;
         b_cnt++;
         if (first_b_edge < 0) first_b_edge = ncyc + 1;
         if (aedge_q.size() != 0) lat_model += 64'(ncyc + 1 - aedge_q.pop_front());
      end
      if (awvalid || wvalid) any_valid = 1;
      if (eoe) begin eoe_cnt++; eoe_edge = ncyc; end
      #1;
   endtask

   task push_expect(input vec_t v);
      exp_aw_t a; exp_w_t w; logic [31:0] off; logic [63:0] chunk;
      off = 32'd0;
      for (int i = 0; i < int'(v.nops); i++) begin
         a.addr = v.init + AW'(off & (v.wgs - 32'd1));
         a.id = IW'(i % 4); a.len = v.exp_len;
         eaw.push_back(a);
         for (int j = 0; j <= int'(v.exp_len); j++) begin
            chunk = {32'(i), 32'(j)};
            w.data = v.pat ? {(DW/64){chunk}} : '0;
            w.last = (j == int'(v.exp_len));
            ew.push_back(w);
         end
         off = off + v.stride;
      end
   endtask

   task start_run(input vec_t v, output int n0);
      lt_params = '0;
      lt_params[31:0] = v.wgs; lt_params[63:32] = v.stride; lt_params[127:64] = v.nops;
      lt_params[159:128] = v.bbytes; lt_params[AW+159:160] = v.init;
      lt_params[240] = v.lat; lt_params[241] = v.pat;
      rnd = v.rnd; bdelay = v.bdelay; emask = v.emask;
      step();
      n0 = ncyc; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task wait_eoe(input int budget, output bit ok);
      int k;
      k = 0;
      while (eoe_cnt == 0 && k < budget) begin step(); k++; end
      ok = (eoe_cnt != 0);
      if (!ok) chk("eoe_timeout", 0, 1);
   endtask

   task finish_checks(input vec_t v, input int n0, input string nm);
      step(); step();
      chk({nm, "_eoe_once"}, DW'(eoe_cnt), 1);
      chk({nm, "_eoe_low"}, DW'(eoe), 0);
      chk({nm, "_aw_left"}, DW'(eaw.size()), 0);
      chk({nm, "_w_left"}, DW'(ew.size()), 0);
      chk({nm, "_wlasts"}, DW'(wlast_cnt), DW'(v.nops));
      chk({nm, "_errcnt"}, DW'(err_cnt), DW'(v.exp_err));
      if (v.lat) begin
         chk({nm, "_lat_sum"}, DW'(lat_sum), DW'(lat_model));
         chk({nm, "_max_out"}, DW'(max_out), 1);
      end else begin
         // RUN entered 3 edges after start is driven; DONE one edge before eoe
         chk({nm, "_tput_sum"}, DW'(lat_sum), DW'(eoe_edge - n0 - 4));
      end
   endtask

   task run_case(input vec_t v, input string nm);
      int n0; bit ok;
      sb_reset();
      push_expect(v);
      start_run(v, n0);
      wait_eoe(20000, ok);
      if (ok) finish_checks(v, n0, nm);
   endtask

   initial begin
      vec_t v; int n0; bit ok;
      //          wgs     stride  nops bbytes init               lat pat rnd bd  emask    len    err
      tbl[0] = '{32'd4096, 32'd256, 64'd8, 32'd256, 33'h1_0000_0000, 0, 1, 0, 2, 8'h00, 8'd3,   32'd0};
      tbl[1] = '{32'd2048, 32'd1024, 64'd5, 32'd64, 33'h0_0000_1000, 0, 0, 0, 1, 8'h00, 8'd0,   32'd0};
      tbl[2] = '{32'd4096, 32'd256, 64'd3, 32'd128, 33'h0_0000_2000, 1, 1, 0, 10, 8'h00, 8'd1,  32'd0};
      tbl[3] = '{32'd4096, 32'd64,  64'd4, 32'd64,  33'h0,           0, 0, 0, 3, 8'h0A, 8'd0,   32'd2};
      tbl[4] = '{32'd256,  32'd100, 64'd6, 32'd512, 33'h1_2345_6700, 0, 1, 1, 4, 8'h00, 8'd7,   32'd0};
      tbl[5] = '{32'd65536, 32'd0,  64'd1, 32'd32768, 33'h0_0001_0000, 0, 1, 0, 1, 8'h00, 8'd255, 32'd0};
      tbl[6] = '{32'd4096, 32'd4096, 64'd2, 32'd16, 33'h0_0004_0000, 0, 1, 0, 1, 8'h00, 8'd0,  32'd0};

      sb_reset();
      rst_n = 1'b0;
      repeat (3) step();
      chk("rst_awvalid", DW'(awvalid), 0);
      chk("rst_wvalid", DW'(wvalid), 0);
      chk("rst_eoe", DW'(eoe), 0);
      chk("rst_lat", DW'(lat_sum), 0);
      chk("rst_err", DW'(err_cnt), 0);
      chk("rst_awaddr", DW'(awaddr), 0);
      chk("rst_awid", DW'(awid), 0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 7; i++) run_case(tbl[i], $sformatf("case%0d", i));

      // outstanding cap: B withheld, only 4 AWs may go out
      v = '{32'd4096, 32'd64, 64'd8, 32'd64, 33'h0, 0, 0, 0, 1, 8'h00, 8'd0, 32'd0};
      sb_reset(); push_expect(v); hold_b = 1;
      start_run(v, n0);
      repeat (40) step();
      chk("cap_aw_cnt", DW'(aw_hs_cnt), 4);
      chk("cap_awvalid", DW'(awvalid), 0);
      chk("cap_no_eoe", DW'(eoe_cnt), 0);
      hold_b = 0;
      wait_eoe(2000, ok);
      if (ok) begin
         chk("cap_aw5_after_b", DW'(aw5_edge > first_b_edge), 1);
         finish_checks(v, n0, "cap");
      end

      // zero ops: done pulse 2 cycles after INIT entry, no traffic
      v = '{32'd4096, 32'd64, 64'd0, 32'd64, 33'h0, 0, 0, 0, 1, 8'h00, 8'd0, 32'd0};
      sb_reset();
      start_run(v, n0);
      wait_eoe(50, ok);
      if (ok) chk("zero_eoe_time", DW'(eoe_edge - n0), 4);
      chk("zero_no_valid", DW'(any_valid), 0);

      // reset mid-run
      v = '{32'd4096, 32'd512, 64'd20, 32'd512, 33'h0_0010_0000, 0, 1, 1, 2, 8'h00, 8'd7, 32'd0};
      sb_reset(); push_expect(v);
      start_run(v, n0);
      repeat (30) step();
      rst_n = 1'b0;
      sb_reset();
      step();
      chk("mid_rst_awvalid", DW'(awvalid), 0);
      chk("mid_rst_wvalid", DW'(wvalid), 0);
      chk("mid_rst_awaddr", DW'(awaddr), 0);
      chk("mid_rst_lat", DW'(lat_sum), 0);
      rst_n = 1'b1;
      repeat (10) step();
      chk("mid_rst_idle", DW'(any_valid), 0);
      chk("mid_rst_no_eoe", DW'(eoe_cnt), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
